// File: rtl/pcie_rd_req_scheduler.sv
// PCIe memory-read request scheduler: round-robin arbitration, tag pool, one TLP in flight to the encoder.
// Optional per-tag completion timeout enabled by defining PCIE_RD_TIMEOUT_EN.
module pcie_rd_req_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned NUM_TAGS    = 16,
    parameter logic [15:0] REQ_ID      = 16'h0100,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*16-1:0] req_addr,
    input  logic [NUM_REQ*4-1:0] req_be,
    output logic [NUM_REQ-1:0]   req_grant,
    output logic [7:0]           req_tag,
    input  logic                 tl_tx_wait,
    input  logic                 enc_done,
    output logic                 read_req,
    output logic [15:0]          read_addr,
    output logic [3:0]           bit_enable,
    output logic [7:0]           tag,
    output logic [15:0]          RequesterID,
    input  logic                 cpl_valid,
    input  logic [7:0]           cpl_tag,
    output logic [5:0]           tags_free,
    output logic                 timeout_err
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned TAG_W = $clog2(NUM_TAGS);

    typedef enum logic [1:0] {IDLE, ARB, ISSUE, WAIT_DONE} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [NUM_TAGS-1:0]  busy_q, busy_d;
    logic [NUM_TAGS-1:0]  cpl_mask, free_vec, alloc_mask, expire;
    logic [TAG_W-1:0]     cpl_idx, alloc_idx;
    logic                 cpl_hit, alloc_ok;
    logic [PTR_W-1:0]     gnt_idx, cand;
    logic                 gnt_ok;
    logic                 do_grant, do_issue;
    logic [5:0]           busy_cnt;

    // A completion for a busy tag releases it; it is visible to the allocator in the same cycle.
    always_comb begin
        cpl_idx  = cpl_tag[TAG_W-1:0];
        cpl_hit  = cpl_valid && (32'(cpl_tag) < NUM_TAGS) && busy_q[cpl_idx];
        cpl_mask = '0;
        if (cpl_hit) cpl_mask[cpl_idx] = 1'b1;
        free_vec = ~busy_q | cpl_mask;
    end

    // Lowest-numbered free tag.
    always_comb begin
        alloc_ok  = 1'b0;
        alloc_idx = '0;
        for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                alloc_ok  = 1'b1;
                alloc_idx = TAG_W'(i);
            end
        end
    end

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        gnt_ok  = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            cand = PTR_W'((32'(rr_ptr_q) + 32'(k)) % NUM_REQ);
            if (req_valid[cand]) begin
                gnt_ok  = 1'b1;
                gnt_idx = cand;
            end
        end
    end

`ifdef PCIE_RD_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q [NUM_TAGS];

    // A completion arriving in the expiry cycle takes precedence over the timeout.
    always_comb begin
        expire = '0;
        for (int i = 0; i < int'(NUM_TAGS); i++) begin
            expire[i] = busy_q[i] && !cpl_mask[i] && (cnt_q[i] == CNT_W'(TIMEOUT_CYC - 1));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NUM_TAGS); i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_TAGS); i++) begin
                if (alloc_mask[i] || !busy_d[i]) cnt_q[i] <= '0;
                else                             cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end
`else
    assign expire = '0;
`endif

    always_comb begin
        alloc_mask = '0;
        if (do_grant) alloc_mask[alloc_idx] = 1'b1;
        busy_d   = (busy_q & ~cpl_mask & ~expire) | alloc_mask;
        busy_cnt = '0;
        for (int i = 0; i < int'(NUM_TAGS); i++) busy_cnt = busy_cnt + 6'(busy_d[i]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        do_issue = 1'b0;
        case (state_q)
            IDLE:      if (|req_valid && tags_free != 6'd0) state_d = ARB;
            ARB: begin
                do_grant = gnt_ok && alloc_ok;
                state_d  = do_grant ? ISSUE : IDLE;
            end
            ISSUE: begin
                if (!tl_tx_wait) begin
                    do_issue = 1'b1;
                    state_d  = WAIT_DONE;
                end
            end
            WAIT_DONE: if (enc_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Registered outputs, request latch, tag pool and RR pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_grant   <= '0;
            req_tag     <= '0;
            read_req    <= 1'b0;
            read_addr   <= '0;
            bit_enable  <= '0;
            tag         <= '0;
            RequesterID <= '0;
            rr_ptr_q    <= '0;
            busy_q      <= '0;
            tags_free   <= 6'(NUM_TAGS);
            timeout_err <= 1'b0;
        end else begin
            req_grant   <= do_grant ? (NUM_REQ'(1) << gnt_idx) : '0;
            req_tag     <= do_grant ? 8'(alloc_idx) : 8'h00;
            read_req    <= do_issue;
            RequesterID <= REQ_ID;
            busy_q      <= busy_d;
            tags_free   <= 6'(NUM_TAGS) - busy_cnt;
            timeout_err <= |expire;
            if (do_grant) begin
                read_addr  <= req_addr[32'(gnt_idx)*16 +: 16];
                bit_enable <= req_be[32'(gnt_idx)*4 +: 4];
                tag        <= 8'(alloc_idx);
                rr_ptr_q   <= (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);
            end
        end
    end

endmodule

// File: doc/pcie_rd_req_scheduler.md
PCIE_RD_REQ_SCHEDULER -- requirements
Module: pcie_rd_req_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of read requesters; legal range 2..8.
REQ-002 Parameter NUM_TAGS, default 16: size of the tag pool; legal values 2..32; tags 0..NUM_TAGS-1.
REQ-003 Parameter REQ_ID, default 16'h0100: Requester ID driven to the TLP encoder.
REQ-004 Parameter TIMEOUT_CYC, default 4096: completion timeout in clk cycles; used only when the Configuration macro is defined.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  NUM_REQ  per-requester read request; held until granted.
REQ-008 req_addr  in  NUM_REQ*16  per-requester read address; slice i is bits [16i+15:16i].
REQ-009 req_be  in  NUM_REQ*4  per-requester byte enables.
REQ-010 req_grant  out  NUM_REQ  one-hot, 1-cycle acceptance pulse.
REQ-011 req_tag  out  8  tag assigned to the granted request; valid with req_grant.
REQ-012 tl_tx_wait  in  1  TX backpressure from the PCIe core.
REQ-013 enc_done  in  1  encoder has emitted the EOP of the current TLP.
REQ-014 read_req  out  1  1-cycle launch pulse to the encoder.
REQ-015 read_addr, bit_enable, tag, RequesterID  out  16/4/8/16  encoder request fields; stable from read_req until enc_done.
REQ-016 cpl_valid, cpl_tag  in  1/8  completion received; frees cpl_tag.
REQ-017 tags_free  out  6  count of free tags.
REQ-018 timeout_err  out  1  1-cycle pulse on completion timeout.

Function
REQ-019 The FSM SHALL have the states IDLE, ARB, ISSUE and WAIT_DONE.
REQ-020 IDLE->ARB SHALL occur when any req_valid is high and tags_free>0.
REQ-021 In ARB the block SHALL grant round-robin, starting at the requester after the last grant, and SHALL pulse req_grant and req_tag.
REQ-022 In ARB the block SHALL latch address, byte enables and the lowest-numbered free tag, mark that tag busy, and go to ISSUE.
REQ-023 ISSUE SHALL wait while tl_tx_wait=1, then pulse read_req for one cycle and go to WAIT_DONE.
REQ-024 WAIT_DONE->IDLE SHALL occur on enc_done.
REQ-025 Minimum grant-to-grant spacing SHALL be 4 cycles.
REQ-026 RequesterID SHALL be constantly REQ_ID.
REQ-027 cpl_valid SHALL free cpl_tag on the following cycle.
REQ-028 A completion whose tag is out of range or already free SHALL be ignored.
REQ-029 A completion and an allocation in the same cycle SHALL both take effect.
REQ-030 tags_free SHALL be updated in that same case: net change 0.
REQ-031 tags_free=0 SHALL hold the FSM in IDLE; requesters keep req_valid asserted and no grant is issued.
REQ-032 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.
REQ-033 The round-robin pointer SHALL update only on a grant.
REQ-034 enc_done outside WAIT_DONE SHALL be ignored.

Reset
REQ-035 On rstn low the block SHALL asynchronously enter IDLE.
REQ-036 On rstn low all outputs except tags_free SHALL be 0.
REQ-037 On rstn low the RR pointer SHALL be 0, all tags SHALL be free and tags_free SHALL equal NUM_TAGS.
REQ-038 On rstn low all timeout counters SHALL clear.
REQ-039 Reset mid-operation SHALL abandon the in-flight request and all outstanding tags without a grant or error pulse.

Configuration
REQ-040 Macro PCIE_RD_TIMEOUT_EN defined: each busy tag SHALL have a counter that starts at allocation.
REQ-041 With PCIE_RD_TIMEOUT_EN, when the counter reaches TIMEOUT_CYC the tag SHALL be freed and timeout_err SHALL pulse once.
REQ-042 With PCIE_RD_TIMEOUT_EN, a completion in the expiry cycle SHALL win and no error SHALL be raised.
REQ-043 PCIE_RD_TIMEOUT_EN undefined: no timeout logic; timeout_err SHALL be tied 0; tags free only on completion.

Verification
REQ-044 Scenario: req_valid=4'b0101, tl_tx_wait=0, enc_done 2 cycles after read_req -> grants go to 0 then 2; tags 0 then 1; read_addr matches each slice.
REQ-045 Scenario: tl_tx_wait held 10 cycles in ISSUE -> read_req held off; it fires on the first cycle after wait drops; fields stay stable.
REQ-046 Scenario: 16 grants with no completions -> tags_free=0 and no further grant; cpl_tag=5 -> the next grant carries tag 5.
REQ-047 Scenario: cpl_valid for tag 3 in the same cycle as allocation of tag 3 -> tags_free unchanged; a duplicate cpl_tag=3 is ignored.
REQ-048 Scenario (PCIE_RD_TIMEOUT_EN, TIMEOUT_CYC=64): no completion -> timeout_err pulses at cycle 64 after allocation and tags_free increments.
REQ-049 Scenario: rstn asserted in WAIT_DONE with 3 tags busy -> all outputs 0 and tags_free=16 immediately.
